// File: rtl/flexible_downsampling_stream.sv
//------------------------------------------------------------------------------
// Module      : flexible_downsampling_stream
// Description : Channel-serial flexible downsampler. Resamples each HIN x HIN
//               channel of a CIN-channel feature map to HOUT x HOUT using a
//               Q8.8 stride (nearest-lower sampling, no interpolation), one
//               output row per cycle, and hands each finished slice to the
//               consumer over a valid/ready handshake.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               start      - 1-cycle run request, honoured only when idle
//               cfg_cin    - channel count for the run (0 or >CIN means CIN)
//               ifmap      - input tensor [row][col][ch], stable for the run
//               out_slice  - downsampled slice of channel out_ch
//               out_ch     - channel index of out_slice
//               out_valid  - out_slice/out_ch valid, held until out_ready
//               out_ready  - consumer accepts the slice
//               busy       - run in progress (sampling or offering a slice)
//               done       - 1-cycle pulse after the last channel handshake
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module flexible_downsampling_stream #(
  parameter  int DW          = 8,
  parameter  int CIN         = 64,
  parameter  int HIN         = 27,
  parameter  int HOUT        = 19,
  parameter  int STRIDE_Q8_8 = 369,
  localparam int CW          = $clog2(CIN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW:0]   cfg_cin,
  input  logic [DW-1:0] ifmap     [HIN][HIN][CIN],
  output logic [DW-1:0] out_slice [HOUT][HOUT],
  output logic [CW-1:0] out_ch,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int RW = $clog2(HOUT);   // output row counter width
  localparam int HW = $clog2(HIN);    // input row/column index width
  // 8 fractional bits plus 8 integer bits cover one stride step; RW extra
  // bits cover HOUT steps, so the accumulator can never wrap.
  localparam int AW = 16 + RW;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_OUT    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    r_state;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_ch;
  logic [CW:0]   r_n;
  logic [DW-1:0] r_slice [HOUT][HOUT];

  logic [HW-1:0] w_col_idx [HOUT];
  logic [AW-1:0] w_acc_int;
  logic [HW-1:0] w_src_row;
  logic [CW:0]   w_n_eff;
  logic          w_last_ch;

  // Column source indices are fixed by the parameters, so they are
  // resolved at elaboration time (with the clamp to the last input column).
  for (genvar gc = 0; gc < HOUT; gc++) begin : g_col
    localparam int RAW = (gc * STRIDE_Q8_8) / 256;
    localparam int SRC = (RAW > HIN - 1) ? HIN - 1 : RAW;
    assign w_col_idx[gc] = HW'(SRC);
  end

  // Integer part of the row accumulator, clamped to the last input row.
  assign w_acc_int = r_acc >> 8;
  assign w_src_row = (w_acc_int > AW'(HIN - 1)) ? HW'(HIN - 1) : w_acc_int[HW-1:0];

  // Out-of-range channel counts fall back to the full channel set.
  assign w_n_eff   = ((cfg_cin == '0) || (cfg_cin > (CW+1)'(CIN))) ? (CW+1)'(CIN) : cfg_cin;
  assign w_last_ch = ({1'b0, r_ch} == (r_n - (CW+1)'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_acc   <= '0;
      r_ch    <= '0;
      r_n     <= '0;
      for (int r = 0; r < HOUT; r++) begin
        for (int c = 0; c < HOUT; c++) begin
          r_slice[r][c] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n     <= w_n_eff;
            r_ch    <= '0;
            r_row   <= '0;
            r_acc   <= '0;
            r_state <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          // One full output row per cycle; rows not yet rewritten keep the
          // previous channel's data.
          for (int c = 0; c < HOUT; c++) begin
            r_slice[r_row][c] <= ifmap[w_src_row][w_col_idx[c]][r_ch];
          end
          r_acc <= r_acc + AW'(STRIDE_Q8_8);
          if (r_row == RW'(HOUT - 1)) begin
            r_row   <= '0;
            r_state <= S_OUT;
          end else begin
            r_row <= r_row + RW'(1);
          end
        end

        S_OUT: begin
          if (out_ready) begin
            if (w_last_ch) begin
              r_state <= S_DONE;
            end else begin
              r_ch    <= r_ch + CW'(1);
              r_row   <= '0;
              r_acc   <= '0;
              r_state <= S_SAMPLE;
            end
          end
        end

        S_DONE: begin
          // start is deliberately not looked at here.
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_slice = r_slice;
  assign out_ch    = r_ch;
  assign out_valid = (r_state == S_OUT);
  // busy drops in the DONE cycle so that it never overlaps the done pulse.
  assign busy      = (r_state == S_SAMPLE) || (r_state == S_OUT);
  assign done      = (r_state == S_DONE);

endmodule

`default_nettype wire
